z_csa_resolve: RTL and testbench
================================

Z_CSA_RESOLVE -- requirements
Module: z_csa_resolve

Interface
REQ-001 Parameter WIDTH, default 16: bit width of the redundant input vectors and the binary result.
REQ-002 Parameter SLICE, default 4: bits resolved per cycle; WIDTH SHALL be an integer multiple of SLICE.
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  sum_vec/carry_vec hold a carry-save word.
REQ-006 in_ready  output  1  block can accept a word.
REQ-007 sum_vec  input  WIDTH  carry-save sum vector; bit i has weight 2^i.
REQ-008 carry_vec  input  WIDTH  carry-save carry vector; bit i has weight 2^(i+1).
REQ-009 out_valid  output  1  result and ovf are valid.
REQ-010 out_ready  input  1  downstream accepts the result.
REQ-011 result  output  WIDTH  binary value (sum_vec + 2*carry_vec) mod 2^WIDTH.
REQ-012 ovf  output  1  true sum >= 2^WIDTH.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, RESOLVE, DONE.
REQ-014 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-015 Accept: in IDLE with in_valid=1, the block SHALL capture sum_vec and {carry_vec[WIDTH-2:0],1'b0}, capture carry_vec[WIDTH-1] as a pending overflow bit, clear the slice index and running carry, and enter RESOLVE.
REQ-016 In IDLE with in_valid=0, all state SHALL hold.
REQ-017 Each RESOLVE cycle SHALL add one SLICE-bit slice of the two operands plus the running carry, starting at the LSB slice, write the slice into result, update the running carry, and increment the slice index.
REQ-018 After WIDTH/SLICE RESOLVE cycles, the FSM SHALL enter DONE, so out_valid rises exactly WIDTH/SLICE clock edges after the accept edge (4 with defaults).
REQ-019 On entry to DONE, ovf SHALL equal the final running carry OR the pending overflow bit.
REQ-020 In DONE, result and ovf SHALL hold stable until out_ready=1; on that edge the FSM SHALL return to IDLE.
REQ-021 out_ready SHALL be ignored outside DONE; in_valid SHALL be ignored outside IDLE, and inputs changing during RESOLVE SHALL NOT affect the result.
REQ-022 No new word SHALL be accepted on the edge that completes a DONE handshake; the minimum accept-to-accept spacing SHALL be WIDTH/SLICE+2 cycles.
REQ-023 Arithmetic SHALL be unsigned; no intermediate truncation is allowed except the final mod 2^WIDTH.
REQ-024 result SHALL be driven only from registers.

Reset
REQ-025 When rst=1 at a rising edge, the FSM SHALL enter IDLE and result, ovf, out_valid, the slice index, running carry and pending bit SHALL be 0, so in_ready is 1 the following cycle.
REQ-026 rst SHALL take priority over every other input, including mid-RESOLVE and in DONE; an aborted word SHALL produce no output.

Verification
REQ-027 A bench SHALL cover each scenario below (WIDTH=16, SLICE=4):
- sum_vec=0x0000, carry_vec=0x0001 -> result=0x0002, ovf=0, out_valid 4 edges after accept.
- sum_vec=0x1234, carry_vec=0x0101 -> result=0x1436, ovf=0.
- sum_vec=0xFFFF, carry_vec=0x0001 -> result=0x0001, ovf=1 (cross-slice ripple to the top).
- sum_vec=0x0000, carry_vec=0x8000 -> result=0x0000, ovf=1 (pending overflow path).
- Result presented with out_ready held 0 for 5 cycles -> result/ovf stable and in_ready=0 throughout; out_ready=1 -> IDLE next edge.
- rst=1 during the 2nd RESOLVE cycle -> next cycle in_ready=1, out_valid=0, result=0x0000, ovf=0; a following word resolves correctly.

Source files
------------

// File: rtl/z_csa_resolve.sv
// Resolves a carry-save (sum, carry) pair into a binary word, SLICE bits per cycle,
// through a three-state accept / resolve / present handshake.
module z_csa_resolve #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] sum_vec,
  input  logic [WIDTH-1:0] carry_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             ovf
);

  localparam int NSL   = WIDTH / SLICE;
  localparam int IDX_W = (NSL > 1) ? $clog2(NSL) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSL - 1);

  typedef enum logic [1:0] {IDLE, RESOLVE, DONE} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_accept;
  logic             w_last;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [IDX_W-1:0] r_idx;
  logic             r_cy;
  logic             r_pend;
  logic [WIDTH-1:0] r_result;
  logic             r_ovf;
  logic [SLICE-1:0] w_a_sl;
  logic [SLICE-1:0] w_b_sl;
  logic [SLICE:0]   w_sum;

  assign w_last = (r_idx == LAST_IDX);

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = RESOLVE;
        end
      end
      RESOLVE: if (w_last) w_state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Slice selection and the SLICE+1 bit adder for the current slice.
  always_comb begin
    w_a_sl = '0;
    w_b_sl = '0;
    for (int k = 0; k < NSL; k++) begin
      if (r_idx == IDX_W'(k)) begin
        w_a_sl = r_a[k*SLICE +: SLICE];
        w_b_sl = r_b[k*SLICE +: SLICE];
      end
    end
    w_sum = {1'b0, w_a_sl} + {1'b0, w_b_sl} + (SLICE+1)'(r_cy);
  end

  // The carry MSB falls off the shifted operand; it is kept as a pending overflow bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_idx    <= '0;
      r_cy     <= 1'b0;
      r_pend   <= 1'b0;
      r_result <= '0;
      r_ovf    <= 1'b0;
    end else if (w_accept) begin
      r_a    <= sum_vec;
      r_b    <= {carry_vec[WIDTH-2:0], 1'b0};
      r_pend <= carry_vec[WIDTH-1];
      r_idx  <= '0;
      r_cy   <= 1'b0;
    end else if (r_state == RESOLVE) begin
      for (int k = 0; k < NSL; k++) begin
        if (r_idx == IDX_W'(k)) r_result[k*SLICE +: SLICE] <= w_sum[SLICE-1:0];
      end
      r_cy  <= w_sum[SLICE];
      r_idx <= r_idx + 1'b1;
      if (w_last) r_ovf <= w_sum[SLICE] | r_pend;
    end
  end

  assign result = r_result;
  assign ovf    = r_ovf;

endmodule

// File: tb/tb_z_csa_resolve.sv
// Scoreboard bench for z_csa_resolve: a driver issues words and queues the
// arithmetic expectation, a monitor compares whenever a result is presented.
module tb_z_csa_resolve;

  localparam int WIDTH = 16;
  localparam int SLICE = 4;
  localparam int NSL   = WIDTH / SLICE;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] sum_vec;
  logic [WIDTH-1:0] carry_vec;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             ovf;

  z_csa_resolve #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .sum_vec(sum_vec), .carry_vec(carry_vec), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [WIDTH-1:0] res;
    logic             ovf;
    int               acc;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: true unsigned sum of sum + 2*carry, no truncation.
  function automatic exp_t model(input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] c, input int acc);
    exp_t e;
    logic [WIDTH+1:0] tot;
    tot   = (WIDTH+2)'(s) + (WIDTH+2)'(c) * 2;
    e.res = tot[WIDTH-1:0];
    e.ovf = (tot >= (WIDTH+2)'(1) << WIDTH);
    e.acc = acc;
    return e;
  endfunction

  // Monitor: compare once per presented result.
  initial begin
    bit   seen;
    exp_t e;
    seen = 1'b0;
    forever begin
      @(negedge clk);
      if (out_valid && !seen) begin
        seen = 1'b1;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got result 0x%0h with empty scoreboard required no output", result);
        end else begin
          e = exp_q.pop_front();
          check("result", result, e.res);
          check("ovf", ovf, e.ovf);
          check("latency", cyc - e.acc, NSL);
        end
      end else if (!out_valid) begin
        seen = 1'b0;
      end
    end
  end

  // Driver: starts and ends at a falling edge.
  task automatic send(input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] c,
                      input int hold, input bit scramble);
    int   n;
    exp_t e;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("wait_in_ready", in_ready, 1);
      return;
    end
    in_valid  = 1'b1;
    sum_vec   = s;
    carry_vec = c;
    out_ready = 1'($urandom);
    @(posedge clk);
    #1;
    e = model(s, c, cyc);
    exp_q.push_back(e);
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 20) begin
      check("in_ready_busy", in_ready, 0);
      in_valid  = scramble ? 1'($urandom) : 1'b0;
      sum_vec   = WIDTH'($urandom);
      carry_vec = WIDTH'($urandom);
      out_ready = 1'($urandom);
      @(negedge clk);
      n++;
    end
    if (!out_valid) begin
      check("done_timeout", out_valid, 1);
      return;
    end
    in_valid  = scramble;
    out_ready = 1'b0;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check("hold_result", result, e.res);
      check("hold_ovf", ovf, e.ovf);
      check("hold_out_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    @(negedge clk);
    check("idle_after_handshake", in_ready, 1);
    check("out_valid_dropped", out_valid, 0);
  endtask

  initial begin
    int n;
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] c;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    sum_vec   = '0;
    carry_vec = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_result", result, 0);
    check("reset_ovf", ovf, 0);

    send(16'h0000, 16'h0001, 0, 0);
    send(16'h1234, 16'h0101, 1, 0);
    send(16'hFFFF, 16'h0001, 0, 1);
    send(16'h0000, 16'h8000, 2, 0);
    send(16'hA5C3, 16'h1F0E, 5, 1);

    // Abort a word with reset during its second resolve cycle.
    in_valid  = 1'b1;
    sum_vec   = 16'hABCD;
    carry_vec = 16'h1234;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_in_ready", in_ready, 1);
    check("abort_out_valid", out_valid, 0);
    check("abort_result", result, 0);
    check("abort_ovf", ovf, 0);
    repeat (NSL + 2) @(negedge clk);
    check("abort_no_output", out_valid, 0);
    send(16'h00FF, 16'h7F81, 1, 1);

    for (int i = 0; i < 150; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      s = WIDTH'($urandom);
      c = WIDTH'($urandom);
      case ($urandom_range(0, 3))
        1: s = '1;
        2: c[WIDTH-1] = 1'b1;
        3: begin s = '1; c = '1; end
        default: ;
      endcase
      send(s, c, $urandom_range(0, 3), 1'($urandom));
    end

    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("scoreboard_drain", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1);
  end

endmodule
